// File: rtl/array_ctrl_pkg.sv
// rtl/array_ctrl_pkg.sv - shared types, latencies and timing helper for the systolic array controller
package array_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_WLOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } array_ctrl_state_t;

  localparam int ARRAY_HEIGHT = 8;
  localparam int ARRAY_WIDTH  = 8;

  // Delays (in cycles) from ifm_rd to the first tap of each skew-line slice
  localparam int LAT_EN_I0 = 1;
  localparam int LAT_EN_O0 = 1 + ARRAY_HEIGHT;
  localparam int LAT_VLD0  = 2 + ARRAY_HEIGHT;

  // Cycle of the done pulse, counted from the cycle the start is accepted
  function automatic int ctrl_done_cycle(input int h, input int w, input int n);
    return (n == 0) ? 1 : (2 * h + w + n + 3);
  endfunction

endpackage

// File: rtl/array_ctrl_skew_line.sv
// rtl/array_ctrl_skew_line.sv - 1-bit shift register with flush, exposing every stage as a tap
module array_ctrl_skew_line #(
  parameter int DEPTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             din,
  output logic [DEPTH-1:0] taps
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // Shift one stage per cycle; a flush empties the whole line at once
  always_comb begin
    sr_d = {sr_q[DEPTH-2:0], din};
    if (flush) begin
      sr_d = '0;
    end
  end

  // Stage register, emptied by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign taps = sr_q;

endmodule

// File: rtl/array_ctrl.sv
// rtl/array_ctrl.sv - tile sequencer: clear, weight preload, skewed input streaming, output drain
module array_ctrl
  import array_ctrl_pkg::*;
#(
  parameter int HEIGHT = 8,
  parameter int WIDTH  = 8,
  parameter int CNTW   = 16,
  localparam int AW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNTW-1:0]   num_vec,
  output logic              busy,
  output logic              done,
  output logic              ifm_rd,
  output logic [CNTW-1:0]   ifm_addr,
  output logic              wght_rd,
  output logic [AW-1:0]     wght_addr,
  output logic [HEIGHT-1:0] en_i,
  output logic [HEIGHT-1:0] clr_i,
  output logic [WIDTH-1:0]  en_w,
  output logic [WIDTH-1:0]  clr_w,
  output logic [WIDTH-1:0]  en_o,
  output logic [WIDTH-1:0]  clr_o,
  output logic [WIDTH-1:0]  ofm_vld
);

  // Stage k of the skew line holds ifm_rd delayed k+1 cycles; the last stage feeds ofm_vld[WIDTH-1]
  localparam int DEPTH = 1 + HEIGHT + WIDTH;
  localparam logic [CNTW-1:0] WLOAD_TOP = CNTW'(HEIGHT - 1);

  array_ctrl_state_t state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [CNTW-1:0]   num_q, num_d;
  logic              zdone_q, zdone_d;
  logic              en_w_q, en_w_d;
  logic [DEPTH-1:0]  taps;

  array_ctrl_skew_line #(
    .DEPTH (DEPTH)
  ) u_skew_line (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .din   (ifm_rd),
    .taps  (taps)
  );

  // State, counter, latched vector count, zero-length done flag and en_w delay
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      zdone_q <= 1'b0;
      en_w_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      zdone_q <= zdone_d;
      en_w_q  <= en_w_d;
    end
  end

  // Next-state logic; a zero-length tile only raises a one-cycle done flag and never leaves IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    zdone_d = 1'b0;
    en_w_d  = (state_q == ST_WLOAD);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_vec == '0) begin
            zdone_d = 1'b1;
          end else begin
            state_d = ST_CLR;
            num_d   = num_vec;
          end
        end
      end
      ST_CLR: begin
        state_d = ST_WLOAD;
        cnt_d   = WLOAD_TOP;
      end
      ST_WLOAD: begin
        if (cnt_q == '0) begin
          state_d = ST_STREAM;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      ST_STREAM: begin
        if (cnt_q == num_q - CNTW'(1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_DRAIN: begin
        // Everything but the last stage empty means the line is empty next cycle
        if (taps[DEPTH-2:0] == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      num_d   = '0;
      zdone_d = 1'b0;
      en_w_d  = 1'b0;
    end
  end

  // Output decode from state, counter and skew-line taps
  always_comb begin
    busy      = (state_q != ST_IDLE) || zdone_q;
    done      = (state_q == ST_DONE) || zdone_q;
    ifm_rd    = (state_q == ST_STREAM);
    ifm_addr  = ifm_rd ? cnt_q : '0;
    wght_rd   = (state_q == ST_WLOAD);
    wght_addr = wght_rd ? cnt_q[AW-1:0] : '0;
    clr_i     = {HEIGHT{state_q == ST_CLR}};
    clr_w     = {WIDTH{state_q == ST_CLR}};
    clr_o     = {WIDTH{state_q == ST_CLR}};
    en_w      = {WIDTH{en_w_q}};
    en_i      = taps[LAT_EN_I0-1 +: HEIGHT];
    en_o      = taps[HEIGHT +: WIDTH];
    ofm_vld   = taps[HEIGHT+1 +: WIDTH];
  end

endmodule

// File: tb/tb_array_ctrl.sv
// tb/tb_array_ctrl.sv - scoreboard bench for array_ctrl against a timing-formula reference model
module tb_array_ctrl;

  localparam int H  = 8;
  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] num_vec = '0;
  logic          busy, done, ifm_rd, wght_rd;
  logic [CW-1:0] ifm_addr;
  logic [2:0]    wght_addr;
  logic [H-1:0]  en_i, clr_i;
  logic [W-1:0]  en_w, clr_w, en_o, clr_o, ofm_vld;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          ifm_rd;
    logic [CW-1:0] ifm_addr;
    logic          wght_rd;
    logic [2:0]    wght_addr;
    logic [H-1:0]  en_i;
    logic [H-1:0]  clr_i;
    logic [W-1:0]  en_w;
    logic [W-1:0]  clr_w;
    logic [W-1:0]  en_o;
    logic [W-1:0]  clr_o;
    logic [W-1:0]  ofm_vld;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;

  // Reference model: 0 idle, 1 running a tile at offset m_t, 2 zero-length done cycle
  int m_mode = 0;
  int m_t    = 0;
  int m_n    = 0;

  array_ctrl #(.HEIGHT(H), .WIDTH(W), .CNTW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .num_vec   (num_vec),
    .busy      (busy),
    .done      (done),
    .ifm_rd    (ifm_rd),
    .ifm_addr  (ifm_addr),
    .wght_rd   (wght_rd),
    .wght_addr (wght_addr),
    .en_i      (en_i),
    .clr_i     (clr_i),
    .en_w      (en_w),
    .clr_w     (clr_w),
    .en_o      (en_o),
    .clr_o     (clr_o),
    .ofm_vld   (ofm_vld)
  );

  always #5 clk = ~clk;

  function automatic int done_at(input int n);
    return 2 * H + W + n + 3;
  endfunction

  // Expected outputs for the current cycle, straight from the tile timing table
  function automatic obs_t expect_now();
    obs_t o;
    int   t;
    int   n;
    o = '0;
    t = m_t;
    n = m_n;
    if (m_mode == 2) begin
      o.busy = 1'b1;
      o.done = 1'b1;
    end else if (m_mode == 1) begin
      o.busy = 1'b1;
      o.done = (t == done_at(n));
      if (t == 1) begin
        o.clr_i = '1;
        o.clr_w = '1;
        o.clr_o = '1;
      end
      if (t >= 2 && t <= H + 1) begin
        o.wght_rd   = 1'b1;
        o.wght_addr = 3'(H + 1 - t);
      end
      if (t >= 3 && t <= H + 2) o.en_w = '1;
      if (t >= H + 2 && t <= H + 1 + n) begin
        o.ifm_rd   = 1'b1;
        o.ifm_addr = CW'(t - (H + 2));
      end
      for (int h = 0; h < H; h++) begin
        if (t >= H + 3 + h && t <= H + 2 + h + n) o.en_i[h] = 1'b1;
      end
      for (int w = 0; w < W; w++) begin
        if (t >= 2 * H + 3 + w && t <= 2 * H + 2 + w + n) o.en_o[w] = 1'b1;
        if (t >= 2 * H + 4 + w && t <= 2 * H + 3 + w + n) o.ofm_vld[w] = 1'b1;
      end
    end
    return o;
  endfunction

  // One cycle: record the expectation for this cycle, drive inputs, advance the model
  task automatic step(input logic s, input logic a, input logic r, input logic [CW-1:0] n);
    @(negedge clk);
    exp_q.push_back(expect_now());
    start   = s;
    abort   = a;
    rst_n   = r;
    num_vec = n;
    if (!r || a) begin
      m_mode = 0;
    end else if (m_mode == 1) begin
      if (m_t == done_at(m_n)) m_mode = 0;
      else m_t = m_t + 1;
    end else if (s) begin
      if (n == '0) begin
        m_mode = 2;
      end else begin
        m_mode = 1;
        m_t    = 1;
        m_n    = int'(n);
      end
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b1, '0);
  endtask

  // Monitor: compare every presented output set against the oldest expectation
  initial begin
    obs_t got;
    obs_t exp;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = '{busy, done, ifm_rd, ifm_addr, wght_rd, wght_addr,
                en_i, clr_i, en_w, clr_w, en_o, clr_o, ofm_vld};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %h expected %h", popped, got, exp);
        end
        popped++;
      end
    end
  end

  initial begin
    int r;
    repeat (2) @(negedge clk);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    // Normal N=4 tile
    step(1'b1, 1'b0, 1'b1, 16'd4);
    idle(40);
    // Zero-length tile
    step(1'b1, 1'b0, 1'b1, 16'd0);
    idle(3);
    // Abort at cycle 15, fresh start at cycle 16
    step(1'b1, 1'b0, 1'b1, 16'd4);
    idle(14);
    step(1'b0, 1'b1, 1'b1, '0);
    step(1'b1, 1'b0, 1'b1, 16'd4);
    idle(40);
    // Start held high across runs (mid-run starts ignored, back-to-back restart)
    for (int i = 0; i < 75; i++) step(1'b1, 1'b0, 1'b1, 16'd3);
    idle(40);
    // Reset pulse at cycle 12
    step(1'b1, 1'b0, 1'b1, 16'd4);
    idle(11);
    step(1'b0, 1'b0, 1'b0, '0);
    idle(40);
    // Single-vector tile
    step(1'b1, 1'b0, 1'b1, 16'd1);
    idle(35);
    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      step((r % 17) == 0, (r % 97) == 3, (r % 331) != 5,
           CW'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20)));
    end
    idle(45);
    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
